// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART memory loader.
// Protocol/receiver state encodings and packet framing constants.
package loader_pkg;

    localparam logic [7:0] LOAD_CMD      = 8'h4C;
    localparam int         PKT_HDR_BYTES = 5;

    typedef enum logic [2:0] {
        P_IDLE,
        P_AHI,
        P_ALO,
        P_LHI,
        P_LLO,
        P_DATA = 3'(PKT_HDR_BYTES),
        P_WRITE,
        P_DONE
    } p_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory-side bus owned by the loader while a program is streamed in.
// master = loader, slave = memory/bus mux.
interface mem_load_if #(
    parameter int ADDR_W = 15
);
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output mem_busy, mem_we, mem_addr, mem_data
    );

    modport slave (
        input mem_busy, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/uart_mem_loader_uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling,
// one-cycle byte_valid or frame_error pulse per frame.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    rx_state_t st, st_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          s1, s2, s_prev;
    logic          tick, half;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half = (cnt == CW'(HALF - 1));

    always_comb begin
        st_n = st;
        unique case (st)
            RX_IDLE:  if (s_prev && !s2) st_n = RX_START;
            RX_START: if (half) st_n = s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) st_n = RX_STOP;
            RX_STOP:  if (tick) st_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= RX_IDLE;
            s1          <= 1'b1;
            s2          <= 1'b1;
            s_prev      <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            st          <= st_n;
            s1          <= rx;
            s2          <= s1;
            s_prev      <= s2;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            cnt <= (st_n != st || tick) ? '0 : cnt + 1'b1;
            if (st == RX_DATA && tick) begin
                byte_data <= {s2, byte_data[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
            if (st == RX_STOP && tick) begin
                byte_valid  <= s2;
                frame_error <= !s2;
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial bootloader: decodes 'L' load packets from UART and writes the
// payload into memory while holding the CPU in reset.
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int ADDR_W         = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    mem_load_if.master mem,
    output logic       cpu_reset_n,
    output logic       load_done,
    output logic [7:0] load_sum,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    p_state_t st, st_n;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len;
    logic [7:0]        data, sum, bd;
    logic [TW-1:0]     tcnt;
    logic              bv, ferr, tout, abort, hdr, busy_n;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (uart_rx),
        .byte_valid  (bv),
        .byte_data   (bd),
        .frame_error (ferr)
    );

    assign tout = (tcnt == TW'(TIMEOUT_CYCLES));
    assign hdr  = (st == P_IDLE) && bv && (bd == LOAD_CMD);

    always_comb begin
        st_n  = st;
        abort = 1'b0;
        unique case (st)
            P_IDLE:  if (hdr) st_n = P_AHI;
            P_AHI:   if (bv) st_n = P_ALO;
            P_ALO:   if (bv) st_n = P_LHI;
            P_LHI:   if (bv) st_n = P_LLO;
            P_LLO:   if (bv) st_n = ({len[15:8], bd} == 16'd0) ? P_DONE : P_DATA;
            P_DATA:  if (bv) st_n = P_WRITE;
            P_WRITE: st_n = (len == 16'd1) ? P_DONE : P_DATA;
            P_DONE:  st_n = P_IDLE;
        endcase
        // A bad frame or stalled sender abandons the load; written bytes stay.
        if (st != P_IDLE && st != P_DONE && (ferr || tout)) begin
            st_n  = P_IDLE;
            abort = 1'b1;
        end
        busy_n = !(st_n == P_IDLE || st_n == P_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= P_IDLE;
            cpu_reset_n <= 1'b0;
            addr        <= '0;
            len         <= '0;
            data        <= '0;
            sum         <= '0;
            load_sum    <= '0;
            frame_err   <= 1'b0;
            tcnt        <= '0;
        end else begin
            st          <= st_n;
            cpu_reset_n <= !busy_n;
            if (st == P_IDLE || bv) tcnt <= '0;
            else if (!tout)         tcnt <= tcnt + 1'b1;
            if (ferr || abort) frame_err <= 1'b1;
            else if (hdr)      frame_err <= 1'b0;
            if (hdr) sum <= '0;
            if (bv && st == P_AHI) addr[ADDR_W-1:8] <= bd[ADDR_W-9:0];
            if (bv && st == P_ALO) addr[7:0] <= bd;
            if (bv && st == P_LHI) len[15:8] <= bd;
            if (bv && st == P_LLO) len[7:0]  <= bd;
            if (bv && st == P_DATA) begin
                data <= bd;
                sum  <= sum + bd;
            end
            if (st == P_WRITE) begin
                addr <= addr + 1'b1;
                len  <= len - 1'b1;
            end
            if (st_n == P_DONE) load_sum <= sum;
        end
    end

    assign mem.mem_busy = !(st == P_IDLE || st == P_DONE);
    assign mem.mem_we   = (st == P_WRITE);
    assign mem.mem_addr = addr;
    assign mem.mem_data = data;
    assign load_done    = (st == P_DONE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: directed packets, queued
// expected writes/load sums checked by an independent monitor.
module tb_uart_mem_loader;
    localparam int C  = 4;
    localparam int TO = 200;
    localparam int AW = 15;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       cpu_reset_n, load_done, frame_err;
    logic [7:0] load_sum;

    mem_load_if #(.ADDR_W(AW)) mem_bus ();

    uart_mem_loader #(
        .CLKS_PER_BIT   (C),
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_rx     (uart_rx),
        .mem         (mem_bus),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_sum    (load_sum),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:32767];
    always @(posedge clk)
        if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_data;

    logic [22:0] wr_q[$];
    logic [7:0]  done_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_bus.mem_we) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_extra: got write %h=%h want none",
                         mem_bus.mem_addr, mem_bus.mem_data);
            end else begin
                logic [22:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_bus.mem_addr), 32'(e[22:8]));
                chk("wr_data", 32'(mem_bus.mem_data), 32'(e[7:0]));
                chk("wr_cpu_rst", 32'(cpu_reset_n), 32'd0);
                chk("wr_busy", 32'(mem_bus.mem_busy), 32'd1);
            end
        end
        if (reset_n && load_done) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_extra: got load_done sum %h want none",
                         load_sum);
            end else begin
                logic [7:0] s;
                s = done_q.pop_front();
                chk("done_sum", 32'(load_sum), 32'(s));
                chk("done_busy", 32'(mem_bus.mem_busy), 32'd0);
                chk("done_cpu_rst", 32'(cpu_reset_n), 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (C) @(negedge clk);
        end
        uart_rx = stop;
        repeat (C) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic send(input bq_t bs);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
    endtask

    task automatic exp_wr(input logic [14:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic chk_idle(input string name, input logic fe);
        chk({name, "_busy"}, 32'(mem_bus.mem_busy), 32'd0);
        chk({name, "_cpu"}, 32'(cpu_reset_n), 32'd1);
        chk({name, "_ferr"}, 32'(frame_err), 32'(fe));
        chk({name, "_wrq"}, 32'(wr_q.size()), 32'd0);
        chk({name, "_doneq"}, 32'(done_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_busy"}, 32'(mem_bus.mem_busy), 32'd0);
        chk({name, "_we"}, 32'(mem_bus.mem_we), 32'd0);
        chk({name, "_addr"}, 32'(mem_bus.mem_addr), 32'd0);
        chk({name, "_data"}, 32'(mem_bus.mem_data), 32'd0);
        chk({name, "_cpu"}, 32'(cpu_reset_n), 32'd0);
        chk({name, "_done"}, 32'(load_done), 32'd0);
        chk({name, "_sum"}, 32'(load_sum), 32'd0);
        chk({name, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_rise", 32'(cpu_reset_n), 32'd1);
        repeat (4) @(negedge clk);

        // 1: basic load
        exp_wr(15'h0010, 8'hA9);
        exp_wr(15'h0011, 8'h01);
        exp_wr(15'h0012, 8'h60);
        done_q.push_back(8'h0A);
        send('{8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h60});
        chk_idle("t1", 1'b0);
        chk("t1_ram10", 32'(ram[15'h0010]), 32'hA9);
        chk("t1_ram12", 32'(ram[15'h0012]), 32'h60);

        // 2: address wrap
        exp_wr(15'h7FFE, 8'h11);
        exp_wr(15'h7FFF, 8'h22);
        exp_wr(15'h0000, 8'h33);
        exp_wr(15'h0001, 8'h44);
        done_q.push_back(8'hAA);
        send('{8'h4C, 8'h7F, 8'hFE, 8'h00, 8'h04,
               8'h11, 8'h22, 8'h33, 8'h44});
        chk_idle("t2", 1'b0);
        chk("t2_ram7fff", 32'(ram[15'h7FFF]), 32'h22);
        chk("t2_ram0000", 32'(ram[15'h0000]), 32'h33);

        // 3: zero length
        done_q.push_back(8'h00);
        send('{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00});
        chk_idle("t3", 1'b0);

        // 4: junk first, ADDR_HI bit7 ignored
        exp_wr(15'h0020, 8'h12);
        exp_wr(15'h0021, 8'h34);
        done_q.push_back(8'h46);
        send('{8'h55, 8'hAA, 8'h4C, 8'h80, 8'h20, 8'h00, 8'h02,
               8'h12, 8'h34});
        chk_idle("t4", 1'b0);
        chk("t4_ram21", 32'(ram[15'h0021]), 32'h34);

        // 5: framing error on payload, then recovery
        send('{8'h4C, 8'h01, 8'h00, 8'h00, 8'h02});
        chk("t5_hdr_busy", 32'(mem_bus.mem_busy), 32'd1);
        chk("t5_hdr_cpu", 32'(cpu_reset_n), 32'd0);
        send_byte(8'h5A, 1'b0);
        chk_idle("t5", 1'b1);
        send('{8'h4C});
        chk("t5_clr_ferr", 32'(frame_err), 32'd0);
        chk("t5_clr_busy", 32'(mem_bus.mem_busy), 32'd1);
        done_q.push_back(8'h00);
        send('{8'h00, 8'h00, 8'h00, 8'h00});
        chk_idle("t5b", 1'b0);

        // 6a: timeout mid-payload
        exp_wr(15'h0200, 8'hDE);
        exp_wr(15'h0201, 8'hAD);
        send('{8'h4C, 8'h02, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD});
        chk("t6_pre_busy", 32'(mem_bus.mem_busy), 32'd1);
        repeat (250) @(negedge clk);
        chk_idle("t6a", 1'b1);
        chk("t6a_ram201", 32'(ram[15'h0201]), 32'hAD);

        // 6b: reset mid-payload
        exp_wr(15'h0300, 8'hC1);
        exp_wr(15'h0301, 8'hC2);
        send('{8'h4C, 8'h03, 8'h00, 8'h00, 8'h04, 8'hC1, 8'hC2});
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6b");
        chk("t6b_wrq", 32'(wr_q.size()), 32'd0);
        chk("t6b_ram300", 32'(ram[15'h0300]), 32'hC1);
        chk("t6b_ram301", 32'(ram[15'h0301]), 32'hC2);
        chk("t6b_ram10", 32'(ram[15'h0010]), 32'hA9);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("t6b_post", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
